// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   - FSM state encodings (also visible on the controller's state output)
//   - debounce-cycle helper derived from clock frequency and debounce time
//   - all-9s BCD constant builder, used by the optional saturation feature
// Optional feature macro: STOPWATCH_SATURATE_EN (used in stopwatch_ctrl).
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_LAP     = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StRunning = ST_RUNNING,
        StPaused  = ST_PAUSED,
        StLap     = ST_LAP
    } state_e;

    // Upper bound on digits handled by all_nines(); NUMCELLS must not exceed it.
    localparam int unsigned MAX_CELLS = 16;

    // Number of consecutive stable cycles before a button level is accepted.
    function automatic int unsigned db_cycles(input int unsigned clockspeed,
                                              input int unsigned debounce_ms);
        return (clockspeed / 1000) * debounce_ms;
    endfunction

    // BCD value with the lowest numcells digits set to 9, rest zero.
    function automatic logic [4*MAX_CELLS-1:0] all_nines(input int unsigned numcells);
        logic [4*MAX_CELLS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_CELLS; i++) begin
            if (i < numcells) begin
                v[4*i +: 4] = 4'h9;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_debounce.sv
// Single push-button conditioner.
// A 2-flop synchroniser feeds a stability counter; the synchronised level is
// accepted once it has differed from the accepted level for DB_CYCLES
// consecutive cycles. A rising edge of the accepted level gives a one-cycle
// press pulse; holding or releasing the button gives nothing further.
// Ports:
//   clock  system clock
//   rst    synchronous active-low reset
//   raw    raw asynchronous button level, active-high
//   press  one-cycle pulse on an accepted 0->1 change
module button_debounce #(
    parameter int unsigned DB_CYCLES = 12
) (
    input  logic clock,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any disagreement restarts the count, so bounce shorter than
    // DB_CYCLES never reaches acceptance.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            sync_q       <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= {sync_q[0], raw};
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM.
// Sequences the BCD timer from start/stop, lap and clear buttons: drives the
// timer's count-enable and clear, captures a lap snapshot, and selects live or
// frozen digits for the 7-segment path.
// Parameters:
//   CLOCKSPEED   system clock frequency in Hz
//   DEBOUNCE_MS  button debounce time in ms
//   NUMCELLS     number of BCD digits (must match the timer)
// Ports:
//   clock           system clock
//   rst             synchronous active-low reset
//   btn_start_stop  raw start/stop button, active-high
//   btn_lap         raw lap button, active-high
//   btn_clear       raw clear button, active-high
//   elapsed         BCD count from the timer, digit 0 in [3:0]
//   timer_run       timer count-enable
//   timer_clear     timer clear, active-high
//   display         BCD digits to the segment driver
//   state           current FSM state encoding
//   lap_active      high while the display is frozen on the lap value
// Optional feature: define STOPWATCH_SATURATE_EN to pause the timer when the
// count reaches all 9s instead of letting it wrap.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLOCKSPEED  = 12000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned NUMCELLS    = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  btn_start_stop,
    input  logic                  btn_lap,
    input  logic                  btn_clear,
    input  logic [4*NUMCELLS-1:0] elapsed,
    output logic                  timer_run,
    output logic                  timer_clear,
    output logic [4*NUMCELLS-1:0] display,
    output logic [1:0]            state,
    output logic                  lap_active
);

    localparam int unsigned DB_CYCLES = db_cycles(CLOCKSPEED, DEBOUNCE_MS);
    localparam int unsigned W         = 4 * NUMCELLS;

    logic press_start_stop, press_lap, press_clear;
    logic ev_clear, ev_start_stop, ev_lap, start_ok;

    state_e         state_q, state_d;
    logic [W-1:0]   lap_q, lap_d;
    logic [W-1:0]   display_q;
    logic           timer_run_q, timer_clear_q, lap_active_q;
    logic           clear_fire;

    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_start_stop (
        .clock (clock),
        .rst   (rst),
        .raw   (btn_start_stop),
        .press (press_start_stop)
    );

    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_lap (
        .clock (clock),
        .rst   (rst),
        .raw   (btn_lap),
        .press (press_lap)
    );

    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_clear (
        .clock (clock),
        .rst   (rst),
        .raw   (btn_clear),
        .press (press_clear)
    );

    // Only the highest-priority pulse of a cycle survives, even when the
    // current state ignores it.
    assign ev_clear      = press_clear;
    assign ev_start_stop = press_start_stop & ~press_clear;
    assign ev_lap        = press_lap & ~press_clear & ~press_start_stop;

`ifdef STOPWATCH_SATURATE_EN
    localparam logic [4*MAX_CELLS-1:0] NINES_FULL = all_nines(NUMCELLS);
    localparam logic [W-1:0]           ALL_NINES  = NINES_FULL[W-1:0];

    logic saturated;
    assign saturated = (elapsed == ALL_NINES);
    // A saturated count can only be left through clear.
    assign start_ok  = ev_start_stop & ~saturated;
`else
    assign start_ok  = ev_start_stop;
`endif

    always_comb begin
        state_d    = state_q;
        lap_d      = lap_q;
        clear_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_clear) begin
                    clear_fire = 1'b1;
                end else if (ev_start_stop) begin
                    state_d = StRunning;
                end
            end
            StRunning: begin
                if (ev_start_stop) begin
                    state_d = StPaused;
                end else if (ev_lap) begin
                    state_d = StLap;
                    lap_d   = elapsed;
                end
`ifdef STOPWATCH_SATURATE_EN
                if (saturated) begin
                    state_d = StPaused;
                    lap_d   = lap_q;
                end
`endif
            end
            StPaused: begin
                if (ev_clear) begin
                    state_d    = StIdle;
                    clear_fire = 1'b1;
                end else if (start_ok) begin
                    state_d = StRunning;
                end
            end
            StLap: begin
                if (ev_start_stop) begin
                    state_d = StPaused;
                end else if (ev_lap) begin
                    state_d = StRunning;
                end
`ifdef STOPWATCH_SATURATE_EN
                if (saturated) begin
                    state_d = StPaused;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q       <= StIdle;
            lap_q         <= '0;
            display_q     <= '0;
            timer_run_q   <= 1'b0;
            timer_clear_q <= 1'b1;
            lap_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            lap_q         <= lap_d;
            display_q     <= (state_d == StLap) ? lap_d : elapsed;
            timer_run_q   <= (state_d == StRunning) || (state_d == StLap);
            timer_clear_q <= clear_fire;
            lap_active_q  <= (state_d == StLap);
        end
    end

    assign state       = state_q;
    assign display     = display_q;
    assign timer_run   = timer_run_q;
    assign timer_clear = timer_clear_q;
    assign lap_active  = lap_active_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLOCKSPEED=12000, DEBOUNCE_MS=1
// (12 debounce cycles). Inputs change and outputs are sampled on the falling
// clock edge. Define STOPWATCH_SATURATE_EN to exercise the saturation path.
module tb_stopwatch_ctrl;

    logic        clock = 1'b0;
    logic        rst;
    logic        btn_start_stop, btn_lap, btn_clear;
    logic [15:0] elapsed;
    logic        timer_run, timer_clear, lap_active;
    logic [15:0] display;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    stopwatch_ctrl #(
        .CLOCKSPEED  (12000),
        .DEBOUNCE_MS (1),
        .NUMCELLS    (4)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .elapsed        (elapsed),
        .timer_run      (timer_run),
        .timer_clear    (timer_clear),
        .display        (display),
        .state          (state),
        .lap_active     (lap_active)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int   seen_clear;
        int   lap_entries;
        logic prev_lap;

        rst            = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        elapsed        = 16'h0000;

        // 1. Reset
        cyc(3);
        check("rst_timer_clear", 32'(timer_clear), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_timer_run", 32'(timer_run), 32'd0);
        check("rst_display", 32'(display), 32'h0);
        check("rst_lap_active", 32'(lap_active), 32'd0);
        rst = 1'b1;
        cyc(1);
        check("post_rst_timer_clear", 32'(timer_clear), 32'd0);
        check("post_rst_state", 32'(state), 32'd0);

        // 2. Short glitch rejected, clean press accepted after 15 edges
        btn_start_stop = 1'b1;
        cyc(8);
        btn_start_stop = 1'b0;
        cyc(20);
        check("glitch_state", 32'(state), 32'd0);
        btn_start_stop = 1'b1;
        cyc(14);
        check("ss_edge14_state", 32'(state), 32'd0);
        check("ss_edge14_run", 32'(timer_run), 32'd0);
        cyc(1);
        check("ss_edge15_state", 32'(state), 32'd1);
        check("ss_edge15_run", 32'(timer_run), 32'd1);
        cyc(5);
        btn_start_stop = 1'b0;
        cyc(20);
        check("ss_release_state", 32'(state), 32'd1);

        // 3. Lap freeze and return to live display
        elapsed = 16'h0123;
        cyc(1);
        check("live_display", 32'(display), 32'h0123);
        btn_lap = 1'b1;
        cyc(15);
        check("lap_state", 32'(state), 32'd3);
        check("lap_active_on", 32'(lap_active), 32'd1);
        elapsed = 16'h0456;
        cyc(2);
        check("lap_frozen_display", 32'(display), 32'h0123);
        check("lap_timer_run", 32'(timer_run), 32'd1);
        btn_lap = 1'b0;
        cyc(20);
        check("lap_release_state", 32'(state), 32'd3);
        btn_lap = 1'b1;
        cyc(14);
        check("lap2_edge14_display", 32'(display), 32'h0123);
        cyc(1);
        check("lap2_state", 32'(state), 32'd1);
        check("lap2_display_live", 32'(display), 32'h0456);
        check("lap2_lap_active", 32'(lap_active), 32'd0);
        btn_lap = 1'b0;
        cyc(20);

        // 4. Pause, then simultaneous start_stop + clear -> IDLE with clear pulse
        btn_start_stop = 1'b1;
        cyc(15);
        check("pause_state", 32'(state), 32'd2);
        check("pause_run", 32'(timer_run), 32'd0);
        btn_start_stop = 1'b0;
        cyc(20);
        btn_start_stop = 1'b1;
        btn_clear      = 1'b1;
        cyc(14);
        check("both_edge14_clear", 32'(timer_clear), 32'd0);
        cyc(1);
        check("both_state", 32'(state), 32'd0);
        check("both_clear_pulse", 32'(timer_clear), 32'd1);
        check("both_run", 32'(timer_run), 32'd0);
        cyc(1);
        check("both_clear_drop", 32'(timer_clear), 32'd0);
        check("both_state_hold", 32'(state), 32'd0);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        cyc(20);
        btn_start_stop = 1'b1;
        cyc(15);
        check("restart_state", 32'(state), 32'd1);
        btn_start_stop = 1'b0;
        cyc(20);
        btn_clear  = 1'b1;
        seen_clear = 0;
        repeat (25) begin
            cyc(1);
            if (timer_clear) seen_clear = 1;
        end
        check("run_clear_no_pulse", 32'(seen_clear), 32'd0);
        check("run_clear_state", 32'(state), 32'd1);
        btn_clear = 1'b0;
        cyc(20);

        // 5. Bouncing lap button -> exactly one LAP entry
        lap_entries = 0;
        prev_lap    = lap_active;
        for (int i = 0; i < 10; i++) begin
            btn_lap = (i % 2 == 0);
            repeat (3) begin
                cyc(1);
                if (lap_active && !prev_lap) lap_entries++;
                prev_lap = lap_active;
            end
        end
        btn_lap = 1'b1;
        repeat (30) begin
            cyc(1);
            if (lap_active && !prev_lap) lap_entries++;
            prev_lap = lap_active;
        end
        check("bounce_lap_entries", 32'(lap_entries), 32'd1);
        check("bounce_state", 32'(state), 32'd3);
        check("bounce_display", 32'(display), 32'h0456);
        btn_lap = 1'b0;
        cyc(20);

`ifdef STOPWATCH_SATURATE_EN
        // 6. Saturation at all 9s
        elapsed = 16'h9999;
        cyc(1);
        check("sat_state", 32'(state), 32'd2);
        check("sat_run", 32'(timer_run), 32'd0);
        check("sat_lap_active", 32'(lap_active), 32'd0);
        btn_start_stop = 1'b1;
        cyc(20);
        check("sat_ss_ignored", 32'(state), 32'd2);
        btn_start_stop = 1'b0;
        cyc(20);
        btn_clear = 1'b1;
        cyc(15);
        check("sat_clear_state", 32'(state), 32'd0);
        check("sat_clear_pulse", 32'(timer_clear), 32'd1);
        cyc(1);
        check("sat_clear_drop", 32'(timer_clear), 32'd0);
        btn_clear = 1'b0;
        cyc(20);
`else
        // 6. Without saturation all 9s is just another count
        elapsed = 16'h9999;
        cyc(2);
        check("nosat_state", 32'(state), 32'd3);
        check("nosat_run", 32'(timer_run), 32'd1);
        check("nosat_display", 32'(display), 32'h0456);
        btn_lap = 1'b1;
        cyc(15);
        check("nosat_live_state", 32'(state), 32'd1);
        check("nosat_live_display", 32'(display), 32'h9999);
        elapsed = 16'h0000;
        cyc(1);
        check("nosat_wrap_state", 32'(state), 32'd1);
        check("nosat_wrap_display", 32'(display), 32'h0000);
        btn_lap = 1'b0;
        cyc(20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
